// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared divide opcodes, constants and operand helpers
package div_issue_ctrl_pkg;
  localparam logic [7:0] INST_DIV   = 8'h40;
  localparam logic [7:0] INST_DIVU  = 8'h41;
  localparam logic [7:0] INST_REM   = 8'h42;
  localparam logic [7:0] INST_REMU  = 8'h43;
  localparam logic [7:0] INST_DIVW  = 8'h44;
  localparam logic [7:0] INST_DIVUW = 8'h45;
  localparam logic [7:0] INST_REMW  = 8'h46;
  localparam logic [7:0] INST_REMUW = 8'h47;
  localparam logic [63:0] ZEROWORD  = 64'h0;

  function automatic logic is_div_op(input logic [7:0] op);
    return op inside {INST_DIV, INST_DIVU, INST_REM, INST_REMU, INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
  endfunction

  function automatic logic is_w_op(input logic [7:0] op);
    return op inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
  endfunction

  function automatic logic is_rem_op(input logic [7:0] op);
    return op inside {INST_REM, INST_REMU, INST_REMW, INST_REMUW};
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return op inside {INST_DIV, INST_REM, INST_DIVW, INST_REMW};
  endfunction

  function automatic logic [63:0] prep_operand(input logic [7:0] op, input logic [63:0] x);
    return !is_w_op(op) ? x : is_signed_op(op) ? {{32{x[31]}}, x[31:0]} : {32'h0, x[31:0]};
  endfunction

  function automatic logic [63:0] w_ext(input logic [7:0] op, input logic [63:0] x);
    return is_w_op(op) ? {{32{x[31]}}, x[31:0]} : x;
  endfunction
endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: EX-stage and divider handshake bundle for the divide front end
interface div_issue_ctrl_if;
  logic        ex_valid;
  logic [7:0]  ex_opcode;
  logic        ex_flush;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] div_dividend;
  logic [63:0] div_diviser;
  logic [7:0]  div_opcode;
  logic        div_ready;
  logic [63:0] div_rem_data;
  logic        div_finish;
  logic        stall_req;
  logic        result_valid;
  logic [63:0] result;
  modport master (
    output ex_valid, ex_opcode, ex_flush, rs1_data, rs2_data, div_rem_data, div_finish,
    input  div_dividend, div_diviser, div_opcode, div_ready, stall_req, result_valid, result
  );
  modport slave (
    input  ex_valid, ex_opcode, ex_flush, rs1_data, rs2_data, div_rem_data, div_finish,
    output div_dividend, div_diviser, div_opcode, div_ready, stall_req, result_valid, result
  );
endinterface

// File: rtl/div_issue_ctrl_special_case.sv
// div_issue_ctrl_special_case: resolves divide-by-zero and signed overflow without the divider
module div_issue_ctrl_special_case
  import div_issue_ctrl_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        is_special,
  output logic [63:0] special_result
);
  logic div_zero, min_neg, overflow;
  always_comb begin
    div_zero = divisor == ZEROWORD;
    // W operands arrive sign-extended, so the 32-bit minimum shows up as its 64-bit extension
    min_neg = is_w_op(opcode) ? dividend == 64'hFFFF_FFFF_8000_0000 : dividend == 64'h8000_0000_0000_0000;
    overflow = is_signed_op(opcode) & min_neg & (&divisor);
    is_special = div_zero | overflow;
    special_result = div_zero ? (is_rem_op(opcode) ? dividend : '1) : is_rem_op(opcode) ? ZEROWORD : dividend;
  end
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues RV64M divides to the iterative divider and returns the final rd value
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic clk,
  input logic rst,
  div_issue_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  state_t state;
  logic accept, is_special;
  logic [XLEN-1:0] dividend, divisor, special_result;

  assign dividend = prep_operand(bus.ex_opcode, bus.rs1_data);
  assign divisor = prep_operand(bus.ex_opcode, bus.rs2_data);
  assign accept = state == IDLE & bus.ex_valid & is_div_op(bus.ex_opcode) & !bus.ex_flush;
  assign bus.stall_req = accept | state == ISSUE | state == WAIT | (state == DRAIN & bus.ex_valid & is_div_op(bus.ex_opcode));

  div_issue_ctrl_special_case u_special (
    .opcode(bus.ex_opcode),
    .dividend(dividend),
    .divisor(divisor),
    .is_special(is_special),
    .special_result(special_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.div_ready <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result <= ZEROWORD;
      bus.div_dividend <= ZEROWORD;
      bus.div_diviser <= ZEROWORD;
      bus.div_opcode <= '0;
    end else begin
      bus.div_ready <= 1'b0;
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus.div_dividend <= dividend;
          bus.div_diviser <= divisor;
          bus.div_opcode <= bus.ex_opcode;
          if (is_special) begin
            bus.result <= w_ext(bus.ex_opcode, special_result);
            bus.result_valid <= 1'b1;
            state <= DONE;
          end else begin
            bus.div_ready <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= bus.ex_flush ? DRAIN : WAIT;
        // a flush landing on the finish cycle leaves nothing to drain
        WAIT: if (bus.div_finish) begin
          state <= bus.ex_flush ? IDLE : DONE;
          if (!bus.ex_flush) begin
            bus.result <= w_ext(bus.div_opcode, bus.div_rem_data);
            bus.result_valid <= 1'b1;
          end
        end else if (bus.ex_flush) state <= DRAIN;
        DONE: state <= IDLE;
        DRAIN: if (bus.div_finish) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: scoreboard bench with a latency-67 divider model and an arithmetic reference
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;
  typedef struct {logic [63:0] res; int cyc;} exp_t;
  typedef struct {logic [63:0] dvd; logic [63:0] dvs; logic [7:0] op;} prep_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  prep_t pq[$];
  exp_t e;
  prep_t cur;
  logic busy = 1'b0;
  int dcnt = 0;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  div_issue_ctrl_if bus ();
  div_issue_ctrl #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [63:0] prep(input logic [7:0] op, input logic [63:0] x);
    if (op == INST_DIVW || op == INST_REMW) return {{32{x[31]}}, x[31:0]};
    if (op == INST_DIVUW || op == INST_REMUW) return {32'h0, x[31:0]};
    return x;
  endfunction

  function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                                          output logic special, output logic is_div);
    logic signed [63:0] sa, sb64;
    logic signed [31:0] sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    logic w, z64, z32, o64, o32;
    sa = a; sb64 = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    z64 = b == 0; z32 = b32 == 0;
    o64 = a == MIN64 && b == '1; o32 = a32 == 32'h8000_0000 && b32 == '1;
    r = 0; r32 = 0; w = 0; special = 0; is_div = 1;
    case (op)
      INST_DIV: begin special = z64 | o64; if (z64) r = '1; else if (o64) r = a; else r = sa / sb64; end
      INST_DIVU: begin special = z64; r = z64 ? '1 : a / b; end
      INST_REM: begin special = z64 | o64; if (z64) r = a; else if (o64) r = 0; else r = sa % sb64; end
      INST_REMU: begin special = z64; r = z64 ? a : a % b; end
      INST_DIVW: begin w = 1; special = z32 | o32; if (z32) r32 = '1; else if (o32) r32 = a32; else r32 = sa32 / sb32; end
      INST_DIVUW: begin w = 1; special = z32; r32 = z32 ? '1 : a32 / b32; end
      INST_REMW: begin w = 1; special = z32 | o32; if (z32) r32 = a32; else if (o32) r32 = 0; else r32 = sa32 % sb32; end
      INST_REMUW: begin w = 1; special = z32; r32 = z32 ? a32 : a32 % b32; end
      default: is_div = 0;
    endcase
    if (w) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // raw divider behaviour: full-width quotient/remainder, no W narrowing
  function automatic logic [63:0] div_unit(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb64;
    logic sg, rm;
    sa = a; sb64 = b;
    sg = op inside {INST_DIV, INST_REM, INST_DIVW, INST_REMW};
    rm = op inside {INST_REM, INST_REMU, INST_REMW, INST_REMUW};
    if (b == 0) return '1;
    if (sg) return rm ? sa % sb64 : sa / sb64;
    return rm ? a % b : a / b;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = 0;
      1: r = '1;
      2: r = MIN64;
      3: r[31:0] = 32'h8000_0000;
      4: r[31:0] = 32'h0;
      5: r = 64'($urandom_range(1, 50));
      6: r[31:0] = 32'hFFFF_FFFF;
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    bus.div_finish = 1'b0;
    if (rst) begin
      busy = 1'b0;
      dcnt = 0;
    end else begin
      if (bus.div_ready) chk("ready_while_busy", 64'(busy), 64'd0);
      if (busy) begin
        dcnt++;
        if (dcnt == 67) begin
          chk("hold_dividend", bus.div_dividend, cur.dvd);
          chk("hold_divisor", bus.div_diviser, cur.dvs);
          chk("hold_opcode", 64'(bus.div_opcode), 64'(cur.op));
          bus.div_rem_data = div_unit(bus.div_opcode, bus.div_dividend, bus.div_diviser);
          bus.div_finish = 1'b1;
          busy = 1'b0;
        end
      end
      if (bus.div_ready) begin
        chk("prep_pending", 64'(pq.size()), 64'd1);
        if (pq.size() > 0) begin
          cur = pq.pop_front();
          chk("div_dividend", bus.div_dividend, cur.dvd);
          chk("div_diviser", bus.div_diviser, cur.dvs);
          chk("div_opcode", 64'(bus.div_opcode), 64'(cur.op));
        end
        busy = 1'b1;
        dcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      chk("rv_pending", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("rv_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_done(input int exp_stall, input int exp_rdy);
    int sc = 0, rc = 0, rcyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.div_ready) begin
        rc++;
        rcyc = cyc;
      end
      if (!bus.stall_req) break;
      sc++;
    end
    chk("stall_cycles", 64'(sc), 64'(exp_stall));
    chk("ready_count", 64'(rc), exp_rdy < 0 ? 64'd0 : 64'd1);
    chk("ready_cycle", 64'(rcyc), 64'(exp_rdy));
    @(posedge clk);
    #1 bus.ex_valid = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic sp, dv;
    logic [63:0] r;
    int t0;
    r = ref_div(op, a, b, sp, dv);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b1; bus.ex_opcode = op; bus.rs1_data = a; bus.rs2_data = b;
    t0 = cyc;
    if (dv) sb.push_back('{r, t0 + (sp ? 1 : 69)});
    if (dv && !sp) pq.push_back('{prep(op, a), prep(op, b), op});
    wait_done(!dv ? 0 : sp ? 1 : 69, (dv && !sp) ? t0 + 1 : -1);
    @(negedge clk);
    if (dv) chk("result_held", bus.result, r);
  endtask

  task automatic flush_test();
    logic sp, dv;
    logic [63:0] r;
    int t0;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b1; bus.ex_opcode = INST_DIV; bus.rs1_data = 64'd1000; bus.rs2_data = 64'd9;
    t0 = cyc;
    pq.push_back('{64'd1000, 64'd9, INST_DIV});
    repeat (20) @(posedge clk);
    #1 bus.ex_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.ex_flush = 1'b0; bus.ex_opcode = INST_REMU; bus.rs1_data = 64'd1000; bus.rs2_data = 64'd7;
    r = ref_div(INST_REMU, 64'd1000, 64'd7, sp, dv);
    // old op finishes at t0+68, the new one is accepted the cycle after
    sb.push_back('{r, t0 + 138});
    pq.push_back('{64'd1000, 64'd7, INST_REMU});
    wait_done(117, t0 + 70);
    @(negedge clk);
    chk("flush_result_held", bus.result, r);
  endtask

  task automatic reset_test();
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b1; bus.ex_opcode = INST_DIV; bus.rs1_data = 64'd12345; bus.rs2_data = 64'd11;
    pq.push_back('{64'd12345, 64'd11, INST_DIV});
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("rst_div_ready", 64'(bus.div_ready), 64'd0);
    chk("rst_result_valid", 64'(bus.result_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_stall", 64'(bus.stall_req), 64'd0);
    chk("rst_dividend", bus.div_dividend, 64'd0);
    chk("rst_diviser", bus.div_diviser, 64'd0);
    chk("rst_opcode", 64'(bus.div_opcode), 64'd0);
    do_op(INST_DIV, 64'd100, 64'd7);
  endtask

  initial begin
    logic [7:0] ops [10];
    ops = '{INST_DIV, INST_DIVU, INST_REM, INST_REMU, INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW, 8'h00, 8'h13};
    bus.ex_valid = 1'b0; bus.ex_flush = 1'b0; bus.ex_opcode = 8'h0; bus.rs1_data = 0; bus.rs2_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_div_ready", 64'(bus.div_ready), 64'd0);
    chk("init_result_valid", 64'(bus.result_valid), 64'd0);
    chk("init_result", bus.result, 64'd0);
    chk("init_stall", 64'(bus.stall_req), 64'd0);
    chk("init_dividend", bus.div_dividend, 64'd0);
    chk("init_opcode", 64'(bus.div_opcode), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_op(INST_DIV, -64'sd7, 64'd2);
    do_op(INST_REMUW, 64'hFFFF_FFFF_0000_0007, 64'd3);
    do_op(INST_DIVU, 64'h1234, 64'd0);
    do_op(INST_REM, 64'd5, 64'd0);
    do_op(INST_DIVW, 64'h8000_0000, 64'hFFFF_FFFF);
    do_op(INST_REMW, 64'h8000_0000, 64'hFFFF_FFFF);
    do_op(INST_DIV, MIN64, '1);
    do_op(INST_DIVUW, 64'hFFFF_FFFF, 64'd1);
    do_op(INST_REMU, 64'd77, 64'h1_0000_0000);
    do_op(8'h13, 64'd9, 64'd3);
    flush_test();
    reset_test();
    for (int i = 0; i < 40; i++) do_op(ops[$urandom_range(0, 9)], pick(), pick());
    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("prep_drained", 64'(pq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage front end for the iterative 64-bit divider. Decodes the eight RV64M divide/remainder opcodes, prepares operands (W-variant extension), resolves divide-by-zero and signed-overflow cases locally, issues a single-cycle start pulse to the divider, holds operands and opcode stable until the divider finishes, then returns the architecturally correct, W-sign-extended result to the EX/MEM boundary while stalling the pipeline.

## Interface
Parameters:
- XLEN, 64, datapath width (only 64 supported)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_opcode  in  8  internal opcode (shared defines)
- ex_flush  in  1  kill the current EX instruction
- rs1_data  in  64  dividend source
- rs2_data  in  64  divisor source
- div_dividend  out  64  operand to divider, held stable
- div_diviser  out  64  operand to divider, held stable
- div_opcode  out  8  opcode to divider, held stable until div_finish sampled
- div_ready  out  1  one-cycle start pulse
- div_rem_data  in  64  divider result (quotient or remainder per opcode)
- div_finish  in  1  divider done, one-cycle pulse
- stall_req  out  1  freeze IF/ID/EX
- result_valid  out  1  one-cycle, result is final
- result  out  64  final rd value

## Operation
- is_div = ex_opcode in {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW}.
- Operand prep: 64-bit ops pass through; DIVW/REMW sign-extend bits[31:0]; DIVUW/REMUW zero-extend bits[31:0].
- Special cases (on prepared operands, W ops judged on 32-bit values):
  - divisor 0: DIV*/DIVU* -> all ones; REM* -> dividend.
  - signed overflow (dividend = most negative, divisor = -1, DIV/REM/DIVW/REMW only): DIV* -> dividend; REM* -> 0.
- W result: result = sign-extend of bits[31:0] (all four W ops, including special cases).
- FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
  - IDLE: ex_valid & is_div & !ex_flush -> latch prepared operands and opcode; special case -> DONE with result computed locally; else -> ISSUE.
  - ISSUE: div_ready=1 -> WAIT.
  - WAIT: div_finish -> capture div_rem_data (W-extend) -> DONE.
  - DONE: result_valid=1 -> IDLE.
  - ex_flush in ISSUE or WAIT -> DRAIN (divider cannot abort; start pulse in ISSUE still issued); DRAIN: div_finish -> IDLE, result discarded.
- stall_req = (IDLE & ex_valid & is_div & !ex_flush) | ISSUE | WAIT | (DRAIN & ex_valid & is_div); low in DONE.
- Non-divide opcodes and ex_valid=0 are ignored in IDLE.

## Timing
- Reset values: state IDLE, div_ready 0, result_valid 0, result 0, stall_req 0, div_dividend/div_diviser 0, div_opcode 0.
- Accept in cycle T; div_ready high in T+1 only; divider asserts div_finish 67 cycles after the div_ready cycle (T+68); result_valid high in T+69.
- Special case: accept in T, result_valid in T+1, div_ready never asserted.
- div_ready never re-asserted before div_finish of the previous operation has been sampled.
- div_opcode/operands unchanged from T+1 through the cycle div_finish is sampled.
- result held after result_valid until the next capture.
- Reset mid-operation: FSM to IDLE immediately; divider is reset by the same rst, so no drain.
- ex_flush in DONE: no effect (result already committed).

## Structure
- Opcode constants (INST_DIV…INST_REMUW) and ZEROWORD come from the shared defines file; FSM state encoding is local.
- One sub-module natural: div_special_case (combinational: prepared operands + opcode -> is_special, special_result).

## Test plan
- DIV rs1=-7, rs2=2 -> div_ready at T+1, result_valid at T+69, result=0xFFFF_FFFF_FFFF_FFFD; stall_req high T..T+68.
- REMUW rs1=0xFFFF_FFFF_0000_0007, rs2=0x3 -> div_dividend=0x7, result=0x1.
- DIVU rs2=0 -> result_valid at T+1, result=0xFFFF_FFFF_FFFF_FFFF, no div_ready; REM rs1=5, rs2=0 -> 5.
- DIVW rs1=0x8000_0000, rs2=0xFFFF_FFFF -> result=0xFFFF_FFFF_8000_0000 at T+1; REMW same -> 0.
- ex_flush in WAIT, new DIV presented -> stall stays high through DRAIN, new op's div_ready only after old div_finish, no result_valid for flushed op.
- rst asserted in WAIT -> next cycle state IDLE, all outputs at reset values; following DIV 100/7 -> 14.
